// File: rtl/bram_arbiter_pkg.sv
// Shared types and constants for the two-requester BRAM arbiter.
package bram_arbiter_pkg;

  localparam int NUM_REQ   = 2;
  localparam int BYTE_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/bram_arbiter_fsm.sv
// Access sequencer and grant selection for bram_arbiter.
// Define BRAM_ARBITER_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module bram_arbiter_fsm
  import bram_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic [NUM_REQ-1:0] pending,
  output logic               grant,
  output logic               access,
  output logic               capture,
  output logic [NUM_REQ-1:0] done
);

  state_t state;
  logic   pick;

`ifdef BRAM_ARBITER_FIXED_PRIO_EN
  assign pick = ~pending[0];
`else
  logic last;
  logic tie;

  // last only moves on a contested grant, so ties alternate
  assign tie  = &pending;
  assign pick = tie ? ~last : ~pending[0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= 1'b0;
      access  <= 1'b0;
      capture <= 1'b0;
      done    <= '0;
`ifndef BRAM_ARBITER_FIXED_PRIO_EN
      last    <= 1'b1;
`endif
    end else if (clk_en) begin
      access  <= 1'b0;
      capture <= 1'b0;
      done    <= '0;
      unique case (state)
        IDLE: begin
          if (|pending) begin
            state  <= ACCESS;
            grant  <= pick;
            access <= 1'b1;
`ifndef BRAM_ARBITER_FIXED_PRIO_EN
            if (tie) last <= pick;
`endif
          end
        end
        ACCESS: begin
          state   <= WAIT;
          capture <= 1'b1;
        end
        WAIT: begin
          state <= DONE;
          done  <= grant ? 2'b10 : 2'b01;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester arbiter in front of a single-port BRAM (1-cycle read).
// Define BRAM_ARBITER_FIXED_PRIO_EN for fixed priority instead of round-robin.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = BYTE_BITS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clk_en,
  input  logic [NUM_REQ-1:0]                 req_trigger,
  input  logic [NUM_REQ-1:0]                 req_wr,
  input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_BITS-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                 req_rdy,
  output logic [NUM_REQ-1:0]                 req_done,
  output logic [NUM_REQ-1:0][DATA_BITS-1:0]  req_rdata,
  output logic                               bram_en,
  output logic                               bram_we,
  output logic [ADDR_BITS-1:0]               bram_addr,
  output logic [DATA_BITS-1:0]               bram_wdata,
  input  logic [DATA_BITS-1:0]               bram_rdata
);

  logic [NUM_REQ-1:0]                pending;
  logic [NUM_REQ-1:0]                wr_q;
  logic [NUM_REQ-1:0][ADDR_BITS-1:0] addr_q;
  logic [NUM_REQ-1:0][DATA_BITS-1:0] wdata_q;
  logic                              grant;
  logic                              access;
  logic                              capture;

  bram_arbiter_fsm u_fsm (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .pending (pending),
    .grant   (grant),
    .access  (access),
    .capture (capture),
    .done    (req_done)
  );

  assign req_rdy    = ~pending;
  assign bram_en    = access;
  assign bram_we    = access & wr_q[grant];
  assign bram_addr  = addr_q[grant];
  assign bram_wdata = wdata_q[grant];

  // a requester's latch is frozen while it is pending, so the
  // granted entry cannot change under an access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      wr_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_rdata <= '0;
    end else if (clk_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_trigger[i] && !pending[i]) begin
          pending[i] <= 1'b1;
          wr_q[i]    <= req_wr[i];
          addr_q[i]  <= req_addr[i];
          wdata_q[i] <= req_wdata[i];
        end
        if (req_done[i]) pending[i] <= 1'b0;
      end
      if (capture && !wr_q[grant]) req_rdata[grant] <= bram_rdata;
    end
  end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, BRAM address width.
REQ-002 SHALL have parameter DATA_BITS, default 8 (`BYTE_BITS`), BRAM data width.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port clk_en, input, 1, global enable; when low, all state and outputs hold.
REQ-006 SHALL have per requester i in {0,1}: req_trigger[i] input 1; req_wr[i] input 1 (1 = write); req_addr[i] input ADDR_BITS; req_wdata[i] input DATA_BITS.
REQ-007 SHALL have per requester i: req_rdy[i] output 1 (idle, trigger accepted); req_done[i] output 1 (one-cycle completion pulse); req_rdata[i] output DATA_BITS (last read result).
REQ-008 SHALL have BRAM port outputs bram_en 1, bram_we 1, bram_addr ADDR_BITS, bram_wdata DATA_BITS, and input bram_rdata DATA_BITS, with 1-cycle read latency.

Function
REQ-009 SHALL accept a trigger only when clk_en=1, req_trigger[i]=1 and req_rdy[i]=1, and ignore it otherwise.
REQ-010 SHALL latch req_wr, req_addr and req_wdata on acceptance, set pending[i], and drive req_rdy[i]=0 from the next cycle.
REQ-011 SHALL run FSM states IDLE, ACCESS, WAIT, DONE; each transition occurs only in cycles with clk_en=1.
REQ-012 SHALL transition IDLE -> ACCESS when any pending bit is set, recording the granted index.
REQ-013 SHALL transition unconditionally ACCESS -> WAIT -> DONE -> IDLE.
REQ-014 SHALL in ACCESS drive bram_en=1, bram_we=latched wr, bram_addr and bram_wdata from the granted latch; otherwise bram_en=0 and bram_we=0.
REQ-015 SHALL in WAIT, for a read, capture bram_rdata into req_rdata[grant]; writes leave req_rdata unchanged.
REQ-016 SHALL in DONE drive req_done[grant]=1 and clear pending[grant]; req_rdy[grant] returns to 1 in the following cycle.
REQ-017 SHALL give trigger-to-done latency of exactly 4 enabled cycles when uncontended (trigger T, ACCESS T+2, WAIT T+3, done T+4).
REQ-018 SHALL, when both are pending in IDLE, grant round-robin to the requester not granted last.
REQ-019 SHALL never lose the losing request, which is served immediately after the current DONE -> IDLE.
REQ-020 SHALL ensure a trigger arriving on requester j during service of i only sets pending[j] and does not disturb the current access.
REQ-021 SHALL never assert req_done for both requesters in the same cycle, nor assert bram_en on two consecutive cycles.

Reset
REQ-022 SHALL, when reset is high, force state IDLE, pending=0, last-grant=1 (so requester 0 wins the first tie), req_rdy=2'b11, req_done=0, bram_en=0, bram_we=0, bram_addr=0, bram_wdata=0, req_rdata=0.
REQ-023 SHALL give reset priority over clk_en, abort any in-flight access with no done pulse, and require requesters to re-trigger.

Configuration
REQ-024 SHALL, with macro BRAM_ARBITER_FIXED_PRIO_EN defined, grant requester 0 whenever both are pending.
REQ-025 SHALL, without BRAM_ARBITER_FIXED_PRIO_EN, use the round-robin arbitration of REQ-018; with the macro defined, the last-grant register does not exist.

Structure
REQ-026 SHALL place the FSM state enum (IDLE/ACCESS/WAIT/DONE) and the requester-count constant (2) in a shared package, bram_arbiter_pkg.
REQ-027 SHALL implement state sequencing and grant selection in sub-module bram_arbiter_fsm; request latches and read-data registers reside in the top.

Verification
REQ-028 SHALL cover: requester 1 reads addr 0x005 holding 0xA7 -> bram_en for exactly 1 cycle at T+2, req_done[1] at T+4, req_rdata[1]=0xA7.
REQ-029 SHALL cover: both trigger the same cycle, requester 0 writes 0x3C to 0x010 and requester 1 reads 0x010 -> requester 0 served first, then requester 1 returns 0x3C; done pulses 4 cycles apart.
REQ-030 SHALL cover: back-to-back simultaneous pairs, 4 rounds -> grants alternate 0,1,1,0,0,1,1,0 (round-robin); with BRAM_ARBITER_FIXED_PRIO_EN the first of each pair is always 0.
REQ-031 SHALL cover: clk_en low for 3 cycles while in WAIT -> outputs frozen, done delayed by exactly 3 cycles, data still correct.
REQ-032 SHALL cover: reset asserted in ACCESS -> no req_done, req_rdy=2'b11 next cycle, BRAM unchanged if the access was a read.
REQ-033 SHALL cover: trigger while req_rdy[i]=0 -> ignored; exactly one done for the original request.
